// File: rtl/debug_read_port.sv
// debug_read_port: valid/ready debug responder reading register file, CCR and idle-slot data memory.
// Optional DBG_TIMEOUT_EN bounds the wait for a free memory slot with an error response.
module debug_read_port #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_COUNT      = 8,
  parameter int MEM_ADDR_WIDTH = 11,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dbg_req_valid,
  output logic                      dbg_req_ready,
  input  logic [1:0]                dbg_req_space,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_req_addr,
  output logic                      dbg_rsp_valid,
  input  logic                      dbg_rsp_ready,
  output logic [DATA_WIDTH-1:0]     dbg_rsp_data,
  output logic                      dbg_rsp_err,
  output logic [2:0]                rf_rd_addr,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data,
  input  logic [2:0]                ccr,
  input  logic                      mem_busy,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);
  typedef enum logic [2:0] {IDLE, REG_RD, MEM_WAIT, MEM_RD, RESP} state_t;
  localparam logic [MEM_ADDR_WIDTH-1:0] REG_LIMIT = MEM_ADDR_WIDTH'(REG_COUNT);
  state_t state, next;
  logic [1:0] space_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic err_q;
  logic timeout;
  logic bad_reg;
  assign bad_reg = space_q == 2'b00 && addr_q >= REG_LIMIT;
`ifdef DBG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] wait_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) wait_cnt <= '0;
    else wait_cnt <= (state == MEM_WAIT && mem_busy) ? wait_cnt + 1'b1 : '0;
  assign timeout = state == MEM_WAIT && mem_busy && wait_cnt == LAST;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:     if (dbg_req_valid) next = dbg_req_space == 2'b10 ? MEM_WAIT : dbg_req_space == 2'b11 ? RESP : REG_RD;
      REG_RD:   next = RESP;
      MEM_WAIT: next = !mem_busy ? MEM_RD : timeout ? RESP : MEM_WAIT;
      MEM_RD:   next = RESP;
      RESP:     if (dbg_rsp_ready) next = IDLE;
      default:  next = IDLE;
    endcase
  end
  always_comb begin
    dbg_req_ready = state == IDLE;
    dbg_rsp_valid = state == RESP;
    mem_rd_en     = state == MEM_WAIT && !mem_busy;
    mem_rd_addr   = addr_q;
    rf_rd_addr    = addr_q[2:0];
    dbg_rsp_data  = data_q;
    dbg_rsp_err   = err_q;
  end
  // response payload is built up in place and held untouched through RESP
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      space_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (state == IDLE && dbg_req_valid) begin
      space_q <= dbg_req_space;
      addr_q  <= dbg_req_addr;
      data_q  <= '0;
      err_q   <= dbg_req_space == 2'b11;
    end else if (state == REG_RD) begin
      data_q  <= space_q == 2'b01 ? DATA_WIDTH'(ccr) : bad_reg ? '0 : rf_rd_data;
      err_q   <= bad_reg;
    end else if (state == MEM_RD) begin
      data_q  <= mem_rd_data;
      err_q   <= 1'b0;
    end else if (timeout) begin
      data_q  <= '0;
      err_q   <= 1'b1;
    end
endmodule

// File: tb/tb_debug_read_port.sv
// tb_debug_read_port: randomized scoreboard bench for debug_read_port against a spec-level read model.
module tb_debug_read_port;
  localparam int DW = 16;
  localparam int AW = 11;
  localparam int TO = 15;
  logic clk = 0;
  logic rst = 0;
  logic req_valid = 0, req_ready;
  logic [1:0] space = 0;
  logic [AW-1:0] addr = 0;
  logic rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic rsp_err;
  logic [2:0] rf_rd_addr;
  logic [DW-1:0] rf_rd_data;
  logic [2:0] ccr = 0;
  logic mem_busy, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] rf [8];
  logic [DW-1:0] mem [2048];
  int cyc = 0, b_lo = 0, b_hi = -1, hold = 0;
  int vec = 0, errs = 0;
  logic stuck = 0, rnd_bp = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc;
    int            lat;
    int            en;
    logic [AW-1:0] addr;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  assign rf_rd_data = rf[rf_rd_addr];
  assign mem_busy = stuck || (cyc >= b_lo && cyc <= b_hi);

  debug_read_port #(.DATA_WIDTH(DW), .REG_COUNT(8), .MEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .dbg_req_valid(req_valid), .dbg_req_ready(req_ready),
    .dbg_req_space(space), .dbg_req_addr(addr),
    .dbg_rsp_valid(rsp_valid), .dbg_rsp_ready(rsp_ready),
    .dbg_rsp_data(rsp_data), .dbg_rsp_err(rsp_err),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .ccr(ccr),
    .mem_busy(mem_busy), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // host response acceptance, with optional forced stalls
  initial begin
    rsp_ready = 1;
    forever begin
      @(negedge clk);
      if (hold > 0 && rsp_valid) begin
        rsp_ready = 0;
        hold--;
      end else rsp_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pops the scoreboard on each new response, checks holds and memory strobes
  initial begin
    exp_t e;
    bit have = 0;
    int en_cnt = 0;
    e = '{default: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        have = 0;
        en_cnt = 0;
      end else begin
        if (mem_rd_en) begin
          en_cnt++;
          chk("mem_rd_en while busy", 32'(mem_busy), 0);
          if (q.size() != 0) chk("mem_rd_addr", 32'(mem_rd_addr), 32'(q[0].addr));
        end
        if (rsp_valid) begin
          if (!have) begin
            if (q.size() == 0) begin
              vec++;
              errs++;
              $display("FAIL unexpected response: got data %0h err %0b expected none", rsp_data, rsp_err);
            end else begin
              e = q.pop_front();
              chk("rsp_data", 32'(rsp_data), 32'(e.data));
              chk("rsp_err", 32'(rsp_err), 32'(e.err));
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
              chk("mem_rd_en pulses", 32'(en_cnt), 32'(e.en));
            end
            en_cnt = 0;
            have = 1;
          end else begin
            chk("held rsp_data", 32'(rsp_data), 32'(e.data));
            chk("held rsp_err", 32'(rsp_err), 32'(e.err));
            chk("req_ready during rsp", 32'(req_ready), 0);
          end
        end else have = 0;
      end
    end
  end

  task automatic req(input logic [1:0] s, input logic [AW-1:0] a, input int b);
    exp_t e;
    int t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      vec++;
      errs++;
      $display("FAIL req_ready wait: got 0 expected 1");
      return;
    end
    e.acc  = cyc;
    e.addr = a;
    e.en   = s == 2'b10 ? 1 : 0;
    e.err  = s == 2'b11 || (s == 2'b00 && a > 11'd7);
    e.data = s == 2'b00 ? (a > 11'd7 ? 16'h0 : rf[a[2:0]]) :
             s == 2'b01 ? {13'h0, ccr} :
             s == 2'b10 ? mem[a] : 16'h0;
    e.lat  = s == 2'b10 ? 3 + b : s == 2'b11 ? 1 : 2;
`ifdef DBG_TIMEOUT_EN
    if (stuck) begin
      e.data = 0;
      e.err  = 1;
      e.lat  = TO + 1;
      e.en   = 0;
    end
`endif
    q.push_back(e);
    b_lo = cyc + 1;
    b_hi = cyc + b;
    req_valid = 1;
    space = s;
    addr = a;
    @(negedge clk);
    req_valid = 0;
    space = 2'($urandom);
    addr = AW'($urandom);
    t = 0;
    while ((q.size() != 0 || !req_ready) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      vec++;
      errs++;
      $display("FAIL response wait: got none expected one");
      q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, ec;
    logic [AW-1:0] a;
    for (int i = 0; i < 2048; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < 8; i++) rf[i] = DW'($urandom);
    repeat (3) @(negedge clk);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_data", 32'(rsp_data), 0);
    chk("reset rsp_err", 32'(rsp_err), 0);
    chk("reset mem_rd_en", 32'(mem_rd_en), 0);
    rst = 1;
    @(negedge clk);
    chk("req_ready after reset", 32'(req_ready), 1);
    rf[1] = 16'h0002;
    req(2'b00, 11'd1, 0);
    ccr = 3'b010;
    req(2'b01, 11'd0, 0);
    req(2'b00, 11'd9, 0);
    req(2'b11, 11'd0, 0);
    mem[2045] = 16'h0002;
    req(2'b10, 11'd2045, 0);
    req(2'b10, 11'd2045, 5);
    hold = 4;
    req(2'b00, 11'd1, 0);
    rnd_bp = 1;
    for (int i = 0; i < 60; i++) begin
      rf[$urandom_range(0, 7)] = DW'($urandom);
      ccr = 3'($urandom);
      a = AW'($urandom);
      mem[a] = DW'($urandom);
      case ($urandom_range(0, 3))
        0: req(2'b00, AW'($urandom_range(0, 11)), 0);
        1: req(2'b01, a, 0);
        2: req(2'b10, $urandom_range(0, 1) ? a : AW'($urandom), $urandom_range(0, 6));
        default: req(2'b11, a, 0);
      endcase
    end
    rnd_bp = 0;
    stuck = 1;
`ifdef DBG_TIMEOUT_EN
    req(2'b10, 11'd2045, 0);
`else
    req_valid = 1;
    space = 2'b10;
    addr = 11'd2045;
    @(negedge clk);
    req_valid = 0;
    vc = 0;
    ec = 0;
    repeat (100) begin
      @(negedge clk);
      vc += 32'(rsp_valid);
      ec += 32'(mem_rd_en);
    end
    chk("stuck busy responses", 32'(vc), 0);
    chk("stuck busy mem_rd_en", 32'(ec), 0);
`endif
    @(negedge clk);
    req_valid = 1;
    space = 2'b10;
    addr = 11'd7;
    @(negedge clk);
    req_valid = 0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("mid-wait reset rsp_valid", 32'(rsp_valid), 0);
    chk("mid-wait reset rsp_data", 32'(rsp_data), 0);
    chk("mid-wait reset rsp_err", 32'(rsp_err), 0);
    chk("mid-wait reset mem_rd_en", 32'(mem_rd_en), 0);
    stuck = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    @(negedge clk);
    chk("req_ready after mid reset", 32'(req_ready), 1);
    repeat (5) @(negedge clk);
    chk("dropped request no rsp", 32'(rsp_valid), 0);
    mem[11'd7] = 16'hbeef;
    req(2'b10, 11'd7, 2);
    req(2'b00, 11'd3, 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/debug_read_port.md
# debug_read_port

Hardware debug responder for the pipelined processor. It lets an external debug host read processor state through a valid/ready request/response interface instead of hierarchical peeks. Readable state is the register file (through a dedicated read port), the condition code register and data memory. Data memory reads are slotted only into cycles the memory stage leaves idle.

## Interface
Parameters:
- DATA_WIDTH, 16, width of registers, memory words and response data
- REG_COUNT, 8, number of architectural registers
- MEM_ADDR_WIDTH, 11, data memory word-address width (2048 words)
- TIMEOUT_CYCLES, 15, maximum MEM_WAIT cycles before an error response (only with DBG_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- dbg_req_valid  in  1  host request valid
- dbg_req_ready  out  1  responder can accept a request
- dbg_req_space  in  2  00 register file, 01 CCR, 10 data memory, 11 reserved
- dbg_req_addr  in  MEM_ADDR_WIDTH  register index or memory word address
- dbg_rsp_valid  out  1  response valid
- dbg_rsp_ready  in  1  host accepts response
- dbg_rsp_data  out  DATA_WIDTH  read data
- dbg_rsp_err  out  1  request failed; data is 0
- rf_rd_addr  out  3  register file debug read address
- rf_rd_data  in  DATA_WIDTH  combinational read data for rf_rd_addr
- ccr  in  3  condition code register {C,N,Z}
- mem_busy  in  1  memory stage uses data memory this cycle
- mem_rd_en  out  1  debug read strobe to data memory
- mem_rd_addr  out  MEM_ADDR_WIDTH  debug read address
- mem_rd_data  in  DATA_WIDTH  memory data, valid the cycle after mem_rd_en

## Operation
- FSM states: IDLE, REG_RD, MEM_WAIT, MEM_RD, RESP.
- IDLE
  - dbg_req_ready=1, combinational from state.
  - On valid&ready, space and addr are latched.
  - Space 00 or 01 goes to REG_RD.
  - Space 10 goes to MEM_WAIT.
  - Space 11 goes to RESP with err=1, data=0.
- REG_RD
  - rf_rd_addr carries the latched addr[2:0].
  - Space 00 captures rf_rd_data.
  - Space 00 with addr ≥ REG_COUNT captures data 0 with err=1.
  - Space 01 captures zero-extended ccr.
  - Always goes to RESP.
- MEM_WAIT
  - mem_rd_en = (state==MEM_WAIT) && !mem_busy.
  - mem_rd_addr is the latched addr.
  - When mem_rd_en=1, goes to MEM_RD.
  - Otherwise the wait counter increments.
- MEM_RD
  - Captures mem_rd_data with err=0.
  - Goes to RESP.
- RESP
  - dbg_rsp_valid=1.
  - dbg_rsp_data and dbg_rsp_err are registered and held stable until dbg_rsp_ready.
  - On the handshake, goes to IDLE.
- dbg_req_ready=0 in every state except IDLE. Exactly one outstanding request.
- mem_rd_en never asserts while mem_busy=1. The processor pipeline is never stalled.
- Reset (rst=0, any state):
  - state returns to IDLE.
  - dbg_rsp_valid=0, dbg_rsp_data=0, dbg_rsp_err=0, mem_rd_en=0, wait counter=0.
  - dbg_req_ready=1 once rst deasserts.
  - An in-flight request is dropped with no response.

## Timing
- Register/CCR: accept at edge N; dbg_rsp_valid high after edge N+2.
- Reserved space: dbg_rsp_valid high after edge N+1.
- Memory, mem_busy low: mem_rd_en high during cycle N+1; dbg_rsp_valid high after edge N+3.
- Each busy cycle in MEM_WAIT adds one cycle of latency.
- Next request can be accepted the cycle after the response handshake. There is no back-to-back overlap.
- Response backpressure is unlimited; outputs hold until dbg_rsp_ready.

## Configuration
- DBG_TIMEOUT_EN defined:
  - The counter in MEM_WAIT runs.
  - If mem_busy stays high for TIMEOUT_CYCLES consecutive cycles, the FSM goes to RESP with err=1, data=0.
  - mem_rd_en is never asserted for that request.
- DBG_TIMEOUT_EN undefined:
  - No counter is built.
  - MEM_WAIT waits indefinitely for mem_busy=0.

## Test plan
- rf model R1=0x0002; request space 00, addr 1 → rf_rd_addr=1; rsp_valid 2 cycles after accept; data 0x0002, err 0.
- ccr=3'b010; request space 01 → data 0x0002, err 0. Request space 00, addr 9 → data 0, err 1. Request space 11 → err 1, 1-cycle latency.
- mem[2045]=0x0002, mem_busy=0; request space 10, addr 2045 → mem_rd_en pulses exactly 1 cycle with mem_rd_addr=2045; response 3 cycles after accept with data 0x0002.
- Same memory read with mem_busy high for 5 cycles after accept → mem_rd_en never overlaps mem_busy; response 8 cycles after accept.
- mem_busy stuck high:
  - With DBG_TIMEOUT_EN → err 1, data 0, no mem_rd_en, response after 15 wait cycles.
  - Without DBG_TIMEOUT_EN → no response after 100 cycles.
- Backpressure and reset:
  - Hold dbg_rsp_ready low 4 cycles → data/err stable and req_ready 0 throughout; accepted on release.
  - rst low mid-MEM_WAIT → all outputs reset; no response; the next request completes normally.
